enigma_engine: RTL

ENIGMA_ENGINE -- requirements
Module: enigma_engine

---
 rtl/enigma_engine.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/enigma_engine.sv
`default_nettype none
// ============================================================================
// Module   : enigma_engine
// Brief    : Multi-rotor Enigma-style cipher, one rotor pass per clock cycle.
// Revision : 1.0
// ============================================================================
module enigma_engine #(
    parameter int NUM_ROTORS = 3,
    parameter int ALPHA      = 26,
    parameter int W          = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            dout,
    output logic                    err,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_kind,
    input  logic [3:0]              cfg_tgt,
    input  logic [W-1:0]            cfg_addr,
    input  logic [W-1:0]            cfg_data,
    output logic [NUM_ROTORS*W-1:0] pos_out
);

    localparam int              c_aw       = (ALPHA > 2) ? $clog2(ALPHA) : 1;
    localparam int              c_rw       = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam logic [W:0]      c_alpha    = (W+1)'(ALPHA);
    localparam logic [W:0]      c_last     = (W+1)'(ALPHA - 1);
    localparam logic [c_rw-1:0] c_last_rot = c_rw'(NUM_ROTORS - 1);
    localparam logic [3:0]      c_refl_tgt = 4'(NUM_ROTORS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_FWD  = 3'd2,
        S_REFL = 3'd3,
        S_BWD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t r_state, w_state_nxt;

    logic [W-1:0]    r_fwd   [NUM_ROTORS][ALPHA];
    logic [W-1:0]    r_inv   [NUM_ROTORS][ALPHA];
    logic [W-1:0]    r_refl  [ALPHA];
    logic [W-1:0]    r_pos   [NUM_ROTORS];
    logic [W-1:0]    r_notch [NUM_ROTORS];
    logic [W-1:0]    r_sym;
    logic [c_rw-1:0] r_rot;
    logic            r_err;

    logic                  w_accept, w_bad_sym, w_cfg_ok, w_cfg_en;
    logic [NUM_ROTORS-1:0] w_adv;
    logic [W-1:0]          w_rot_pos, w_map, w_rot_out;
    logic [W:0]            w_sum, w_diff;
    logic [c_aw-1:0]       w_idx;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_bad_sym = ({1'b0, din} >= c_alpha);

    always_comb begin
        w_cfg_ok = 1'b0;
        if (({1'b0, cfg_addr} < c_alpha) && ({1'b0, cfg_data} < c_alpha)) begin
            case (cfg_kind)
                2'd0:       w_cfg_ok = (cfg_tgt <= c_refl_tgt);
                2'd1, 2'd2: w_cfg_ok = (cfg_tgt < c_refl_tgt);
                default:    w_cfg_ok = 1'b0;
            endcase
        end
    end

    assign w_cfg_en = cfg_we && (r_state == S_IDLE) && w_cfg_ok;

    // Forward and inverse tables are written together so they stay mutual inverses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROTORS; r++) begin
                for (int a = 0; a < ALPHA; a++) begin
                    r_fwd[r][a] <= W'(a);
                    r_inv[r][a] <= W'(a);
                end
            end
            for (int a = 0; a < ALPHA; a++) begin
                r_refl[a] <= W'(ALPHA - 1 - a);
            end
        end else if (w_cfg_en && (cfg_kind == 2'd0)) begin
            if (cfg_tgt == c_refl_tgt) begin
                r_refl[cfg_addr[c_aw-1:0]] <= cfg_data;
            end else begin
                r_fwd[cfg_tgt[c_rw-1:0]][cfg_addr[c_aw-1:0]] <= cfg_data;
                r_inv[cfg_tgt[c_rw-1:0]][cfg_data[c_aw-1:0]] <= cfg_addr;
            end
        end
    end

    // Odometer carry: a rotor moves only if its neighbour moved from its notch.
    always_comb begin
        w_adv    = '0;
        w_adv[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            w_adv[i] = w_adv[i-1] && (r_pos[i-1] == r_notch[i-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                r_pos[i]   <= '0;
                r_notch[i] <= W'(ALPHA - 1);
            end
        end else if (w_cfg_en && (cfg_kind == 2'd1)) begin
            r_pos[cfg_tgt[c_rw-1:0]] <= cfg_data;
        end else if (w_cfg_en && (cfg_kind == 2'd2)) begin
            r_notch[cfg_tgt[c_rw-1:0]] <= cfg_data;
        end else if (r_state == S_STEP) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                if (w_adv[i]) begin
                    r_pos[i] <= ({1'b0, r_pos[i]} == c_last) ? '0 : r_pos[i] + 1'b1;
                end
            end
        end
    end

    // Shared rotor pass: offset by position, look up, remove offset.
    always_comb begin
        w_rot_pos = r_pos[r_rot];
        w_sum     = {1'b0, r_sym} + {1'b0, w_rot_pos};
        w_idx     = (w_sum >= c_alpha) ? c_aw'(w_sum - c_alpha) : c_aw'(w_sum);
        w_map     = (r_state == S_BWD) ? r_inv[r_rot][w_idx] : r_fwd[r_rot][w_idx];
        w_diff    = {1'b0, w_map} + c_alpha - {1'b0, w_rot_pos};
        w_rot_out = (w_diff >= c_alpha) ? W'(w_diff - c_alpha) : W'(w_diff);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_bad_sym ? S_DONE : S_STEP;
                end
            end
            S_STEP: w_state_nxt = S_FWD;
            S_FWD:  if (r_rot == c_last_rot) w_state_nxt = S_REFL;
            S_REFL: w_state_nxt = S_BWD;
            S_BWD:  if (r_rot == '0) w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sym <= '0;
            r_rot <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sym <= din;
                        r_err <= w_bad_sym;
                    end
                end
                S_STEP: r_rot <= '0;
                S_FWD: begin
                    r_sym <= w_rot_out;
                    if (r_rot != c_last_rot) begin
                        r_rot <= r_rot + 1'b1;
                    end
                end
                S_REFL: r_sym <= r_refl[r_sym[c_aw-1:0]];
                S_BWD: begin
                    r_sym <= w_rot_out;
                    if (r_rot != '0) begin
                        r_rot <= r_rot - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = r_sym;
    assign err  = r_err;

    generate
        for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_pos
            assign pos_out[i*W +: W] = r_pos[i];
        end
    endgenerate

endmodule
`default_nettype wire
